// File: rtl/led_trail_pwm.sv
// LED comet-trail driver: per-LED brightness levels are set to max while lit and
// decay on a periodic tick once unlit. Levels are shown through per-LED PWM.
// Shadow registers are reloaded only at the end of each PWM period, so level
// changes never disturb a period that is already running.
// Optional build macro LED_TRAIL_GAMMA_EN: the shadow stores (level*level)>>PWM_BITS
// instead of level, which gives a square-law gamma.
module led_trail_pwm #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned DECAY_PERIOD = 65536,
  parameter int unsigned DECAY_STEP   = 32
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                pattern_valid,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                pwm_wrap
);

  localparam int unsigned DecayW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [PWM_BITS-1:0] LevelMax = {PWM_BITS{1'b1}};
  localparam logic [DecayW-1:0] DecayLast = DecayW'(DECAY_PERIOD - 1);
  // A step larger than the max level clears the level on the first tick.
  localparam bit StepFits = (DECAY_STEP <= (2 ** PWM_BITS - 1));
  localparam logic [PWM_BITS-1:0] StepVal = StepFits ? PWM_BITS'(DECAY_STEP) : '0;

  logic [NUM_LEDS-1:0]                pat_q, pat_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q, level_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  shadow_q, shadow_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [DecayW-1:0]                  decay_cnt_q, decay_cnt_d;
  logic [NUM_LEDS-1:0]                led_out_q, led_out_d;
  logic                               pwm_wrap_q, pwm_wrap_d;
  logic                               decay_tick;
  logic [NUM_LEDS-1:0]                pat_eff;

  // Pattern capture and the two free-running counters.
  always_comb begin
    pat_d       = pattern_valid ? pattern_in : pat_q;
    pat_eff     = pat_d;
    decay_tick  = (decay_cnt_q == DecayLast);
    decay_cnt_d = decay_tick ? '0 : decay_cnt_q + DecayW'(1);
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
  end

  // Per-channel level update: lit holds max, otherwise saturating decay on tick.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pat_eff[i]) begin
        level_d[i] = LevelMax;
      end else if (decay_tick) begin
        if (!StepFits || (level_q[i] < StepVal)) begin
          level_d[i] = '0;
        end else begin
          level_d[i] = level_q[i] - StepVal;
        end
      end
    end
  end

  // Shadow reload at the last PWM count so the next period sees a stable level.
`ifdef LED_TRAIL_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  always_comb begin
    shadow_d = shadow_q;
    sq       = '0;
    if (pwm_cnt_q == LevelMax) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        sq          = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
        shadow_d[i] = sq[2*PWM_BITS-1:PWM_BITS];
      end
    end
  end
`else
  always_comb begin
    shadow_d = shadow_q;
    if (pwm_cnt_q == LevelMax) begin
      shadow_d = level_q;
    end
  end
`endif

  // PWM compare and period-wrap pulse, both registered.
  always_comb begin
    led_out_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_out_d[i] = (pwm_cnt_q < shadow_q[i]);
    end
    pwm_wrap_d = (pwm_cnt_q == LevelMax);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      pat_q       <= '0;
      level_q     <= '0;
      shadow_q    <= '0;
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
      led_out_q   <= '0;
      pwm_wrap_q  <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      level_q     <= level_d;
      shadow_q    <= shadow_d;
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      led_out_q   <= led_out_d;
      pwm_wrap_q  <= pwm_wrap_d;
    end
  end

  assign led_out  = led_out_q;
  assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm with PWM_BITS=4, DECAY_PERIOD=4, DECAY_STEP=5.
// Edge index k counts non-reset edges since the last reset release: decay ticks
// land on k%4==0 and shadow loads on k%16==0.
module tb_led_trail_pwm;
  localparam int unsigned NumLeds     = 8;
  localparam int unsigned PwmBits     = 4;
  localparam int unsigned DecayPeriod = 4;
  localparam int unsigned DecayStep   = 5;
`ifdef LED_TRAIL_GAMMA_EN
  localparam int ExpDuty15 = 14;
  localparam int ExpDuty10 = 6;
  localparam int ExpDuty5  = 1;
`else
  localparam int ExpDuty15 = 15;
  localparam int ExpDuty10 = 10;
  localparam int ExpDuty5  = 5;
`endif

  logic               Clk = 1'b0;
  logic               reset;
  logic [NumLeds-1:0] pattern_in;
  logic               pattern_valid;
  logic [NumLeds-1:0] led_out;
  logic               pwm_wrap;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int cnt0, cnt1, wraps;
  logic [NumLeds-1:0] any_led;
  logic [31:0] any_lvl;

  always #5 Clk = ~Clk;

  led_trail_pwm #(
    .NUM_LEDS    (NumLeds),
    .PWM_BITS    (PwmBits),
    .DECAY_PERIOD(DecayPeriod),
    .DECAY_STEP  (DecayStep)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .pattern_in   (pattern_in),
    .pattern_valid(pattern_valid),
    .led_out      (led_out),
    .pwm_wrap     (pwm_wrap)
  );

  task automatic step();
    @(posedge Clk);
    #1;
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held for 3 edges while a full pattern strobes in: reset wins.
    reset = 1'b1; pattern_valid = 1'b1; pattern_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", 32'(led_out), 32'h0);
      check("rst_wrap", 32'(pwm_wrap), 32'h0);
      check("rst_level", dut.level_q, 32'h0);
    end
    reset = 1'b0; pattern_valid = 1'b0; pattern_in = 8'h00; k = 0;

    step(); // k=1
    check("post_rst_level", dut.level_q, 32'h0);
    check("post_rst_led", 32'(led_out), 32'h0);
    check("post_rst_wrap", 32'(pwm_wrap), 32'h0);

    // Single lit LED.
    pattern_in = 8'h01; pattern_valid = 1'b1;
    step(); // k=2
    check("lit_level", dut.level_q, 32'h0000_000F);
    pattern_valid = 1'b0;
    while (k < 15) step();
    check("wrap_k15", 32'(pwm_wrap), 32'h0);
    step(); // k=16
    check("wrap_k16", 32'(pwm_wrap), 32'h1);
    check("led_k16", 32'(led_out), 32'h0);

    cnt0 = 0; wraps = 0; any_led = '0;
    while (k < 32) begin
      step();
      cnt0 += int'(led_out[0]);
      wraps += int'(pwm_wrap);
      any_led |= led_out & 8'hFE;
    end
    check("duty15_led0", 32'(cnt0), 32'(ExpDuty15));
    check("others_off", 32'(any_led), 32'h0);
    check("wraps_per_period", 32'(wraps), 32'h1);
    check("wrap_k32", 32'(pwm_wrap), 32'h1);

    // Move the dot to LED1 mid-period (pwm_cnt becomes 7 on this edge).
    cnt0 = 0; cnt1 = 0;
    while (k < 38) begin
      step();
      cnt0 += int'(led_out[0]);
      cnt1 += int'(led_out[1]);
    end
    pattern_in = 8'h02; pattern_valid = 1'b1;
    step(); // k=39
    cnt0 += int'(led_out[0]);
    cnt1 += int'(led_out[1]);
    check("move_level", dut.level_q, 32'h0000_00FF);
    pattern_valid = 1'b0;
    while (k < 48) begin
      step();
      cnt0 += int'(led_out[0]);
      cnt1 += int'(led_out[1]);
      if (k == 35 + 5) check("decay_k40", 32'(dut.level_q[0]), 32'd10);
      if (k == 43) check("hold_k43", 32'(dut.level_q[0]), 32'd10);
      if (k == 44) check("decay_k44", 32'(dut.level_q[0]), 32'd5);
    end
    check("decay_k48", 32'(dut.level_q[0]), 32'd0);
    check("held_lit_l1", 32'(dut.level_q[1]), 32'd15);
    check("old_duty_led0", 32'(cnt0), 32'(ExpDuty15));
    check("no_glitch_led1", 32'(cnt1), 32'd0);

    cnt0 = 0; cnt1 = 0;
    while (k < 64) begin
      step();
      cnt0 += int'(led_out[0]);
      cnt1 += int'(led_out[1]);
      if (k == 52) check("sat_k52", 32'(dut.level_q[0]), 32'd0);
    end
    check("new_duty_led0", 32'(cnt0), 32'(ExpDuty5));
    check("new_duty_led1", 32'(cnt1), 32'(ExpDuty15));

    // Simultaneous pattern strobe and decay tick.
    pattern_in = 8'h08; pattern_valid = 1'b1;
    step(); // k=65
    check("l3_lit", 32'(dut.level_q[3]), 32'd15);
    check("l1_hold", 32'(dut.level_q[1]), 32'd15);
    pattern_valid = 1'b0;
    while (k < 67) step();
    pattern_in = 8'h00; pattern_valid = 1'b1;
    step(); // k=68, tick edge
    check("simul_l3", 32'(dut.level_q[3]), 32'd10);
    check("simul_l1", 32'(dut.level_q[1]), 32'd10);
    pattern_in = 8'h20;
    step(); // k=69
    check("l5_lit", 32'(dut.level_q[5]), 32'd15);
    pattern_valid = 1'b0;
    while (k < 72) step();
    check("fade_levels", dut.level_q, 32'h00F0_5050);
    check("pre_rst_led1", 32'(led_out[1]), 32'h1);

    // Mid-fade reset, with a competing strobe.
    reset = 1'b1; pattern_in = 8'hFF; pattern_valid = 1'b1;
    step();
    check("midrst_led", 32'(led_out), 32'h0);
    check("midrst_wrap", 32'(pwm_wrap), 32'h0);
    check("midrst_level", dut.level_q, 32'h0);
    reset = 1'b0; pattern_valid = 1'b0; pattern_in = 8'h00; k = 0;

    any_led = '0; any_lvl = '0;
    while (k < 9) begin
      step();
      any_led |= led_out;
      any_lvl |= dut.level_q;
    end
    check("no_trail_level", any_lvl, 32'h0);

    // Level 10 captured into the shadow: duty shows the gamma curve if enabled.
    pattern_in = 8'h01; pattern_valid = 1'b1;
    step(); // k=10
    any_led |= led_out;
    check("relit_l0", 32'(dut.level_q[0]), 32'd15);
    pattern_valid = 1'b0;
    step(); // k=11
    any_led |= led_out;
    pattern_in = 8'h00; pattern_valid = 1'b1;
    step(); // k=12, tick edge
    any_led |= led_out;
    check("unlit_tick_l0", 32'(dut.level_q[0]), 32'd10);
    pattern_valid = 1'b0;
    while (k < 16) begin
      step();
      any_led |= led_out;
    end
    check("no_trail_led", 32'(any_led), 32'h0);
    check("l0_k16", 32'(dut.level_q[0]), 32'd5);
    check("wrap_after_rst", 32'(pwm_wrap), 32'h1);
    cnt0 = 0;
    while (k < 32) begin
      step();
      cnt0 += int'(led_out[0]);
    end
    check("duty10_led0", 32'(cnt0), 32'(ExpDuty10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
